// File: rtl/rr_arb16.sv
// 16-requester round-robin arbiter with registered one-hot grant and per-grant hold limit.
// Define ARB_PRIORITY0_EN to give requester 0 absolute priority in IDLE.
module rr_arb16 #(
   parameter int HOLD_MAX = 8,
   parameter int PTR_INIT = 0
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        En,
   input  logic [0:15] Req,
   input  logic        Done,
   output logic [0:15] Gnt,
   output logic [3:0]  GntIdx,
   output logic        Valid,
   output logic        Timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] LIM    = 4'(HOLD_MAX - 1);
   localparam bit         LIM_EN = (HOLD_MAX != 0);

   state_t      state, state_n;
   logic [0:15] gnt_n;
   logic [3:0]  idx_n, ptr, ptr_n, cnt, cnt_n, win;
   logic        found, to_n;
   logic        rel_done, rel_wd, rel_lim, rel_en;

   // Scan from the pointer upward, wrapping through the 4-bit add
   always_comb begin
      win   = ptr;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (!found && Req[ptr + 4'(k)]) begin
            win   = ptr + 4'(k);
            found = 1'b1;
         end
      end
`ifdef ARB_PRIORITY0_EN
      if (Req[0]) begin
         win   = 4'd0;
         found = 1'b1;
      end
`endif
   end

   assign rel_done = Done;
   assign rel_wd   = !Req[GntIdx];
   assign rel_lim  = LIM_EN && (cnt == LIM);
   assign rel_en   = !En;

   always_comb begin
      state_n = state;
      gnt_n   = '0;
      idx_n   = GntIdx;
      ptr_n   = ptr;
      cnt_n   = cnt;
      to_n    = 1'b0;
      case (state)
         IDLE: begin
            if (En && found) begin
               state_n    = GRANT;
               gnt_n[win] = 1'b1;
               idx_n      = win;
               cnt_n      = 4'd0;
            end
         end
         GRANT: begin
            if (rel_done || rel_wd || rel_lim || rel_en) begin
               state_n = IDLE;
               // Disable alone leaves the pointer where it was
               if (rel_done || rel_wd || rel_lim)
                  ptr_n = GntIdx + 4'd1;
               to_n = rel_lim && !rel_done && !rel_wd && !rel_en;
            end else begin
               gnt_n = Gnt;
               if (cnt != 4'hf)
                  cnt_n = cnt + 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state   <= IDLE;
         Gnt     <= '0;
         GntIdx  <= 4'd0;
         ptr     <= 4'(PTR_INIT);
         cnt     <= 4'd0;
         Timeout <= 1'b0;
      end else begin
         state   <= state_n;
         Gnt     <= gnt_n;
         GntIdx  <= idx_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         Timeout <= to_n;
      end
   end

   assign Valid = |Gnt;

endmodule

// File: tb/tb_rr_arb16.sv
// Bench for rr_arb16: directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_arb16;

   localparam int HOLD = 8;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        En = 1'b1;
   logic [0:15] Req = '0;
   logic        Done = 1'b0;
   logic [0:15] Gnt;
   logic [3:0]  GntIdx;
   logic        Valid;
   logic        Timeout;

   int checks = 0;
   int failures = 0;

   // Model state: owner is the granted requester or -1, held counts cycles granted so far
   int m_owner = -1;
   int m_ptr = 0;
   int m_last = 0;
   int m_held = 0;
   bit m_to = 1'b0;

   rr_arb16 #(.HOLD_MAX(HOLD), .PTR_INIT(0)) dut (
      .Clock(Clock), .Resetn(Resetn), .En(En), .Req(Req), .Done(Done),
      .Gnt(Gnt), .GntIdx(GntIdx), .Valid(Valid), .Timeout(Timeout)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [0:15] r, input int p);
`ifdef ARB_PRIORITY0_EN
      if (r[0]) return 0;
`endif
      for (int k = 0; k < 16; k++)
         if (r[(p + k) % 16]) return (p + k) % 16;
      return -1;
   endfunction

   // Model step at every rising edge, compare 1 time unit later
   initial begin
      logic [0:15] eg;
      bit rd, rw, rl, re;
      forever begin
         @(posedge Clock);
         if (!Resetn) begin
            m_owner = -1; m_ptr = 0; m_last = 0; m_held = 0; m_to = 1'b0;
         end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
               if (En && (|Req)) begin
                  m_owner = pick(Req, m_ptr);
                  m_last  = m_owner;
                  m_held  = 0;
               end
            end else begin
               m_held++;
               rd = Done;
               rw = !Req[m_owner];
               rl = (HOLD != 0) && (m_held >= HOLD);
               re = !En;
               if (rd || rw || rl || re) begin
                  if (rd || rw || rl) m_ptr = (m_owner + 1) % 16;
                  m_to = rl && !rd && !rw && !re;
                  m_owner = -1;
               end
            end
         end
         #1;
         eg = '0;
         if (m_owner >= 0) eg[m_owner] = 1'b1;
         chk("gnt", int'(Gnt), int'(eg));
         chk("valid", int'(Valid), int'(m_owner >= 0));
         chk("gntidx", int'(GntIdx), m_last);
         chk("timeout", int'(Timeout), int'(m_to));
      end
   end

   task automatic do_reset();
      @(negedge Clock);
      Resetn = 1'b0; Req = '0; Done = 1'b0; En = 1'b1;
      repeat (2) @(negedge Clock);
      Resetn = 1'b1;
   endtask

   initial begin
      do_reset();

      // Idle after reset with no requests
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         chk("idle_valid", int'(Valid), 0);
         chk("idle_gnt", int'(Gnt), 0);
         chk("idle_idx", int'(GntIdx), 0);
      end

      // Single requester, then pointer moves to 6
      Req[5] = 1'b1;
      @(negedge Clock);
      chk("single_idx", int'(GntIdx), 5);
      chk("single_gnt5", int'(Gnt[5]), 1);
      Done = 1'b1;
      @(negedge Clock);
      chk("single_rel", int'(Valid), 0);
      Done = 1'b0; Req[6] = 1'b1;
      @(negedge Clock);
      chk("ptr6_idx", int'(GntIdx), 6);

      // Asynchronous reset during a grant
      #2 Resetn = 1'b0;
      #1 chk("async_gnt", int'(Gnt), 0);
      chk("async_valid", int'(Valid), 0);
      @(negedge Clock);
      Req = '0;
      Resetn = 1'b1;

      // Full rotation with wrap
      @(negedge Clock);
      Req = '1; Done = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge Clock);
         chk("rot_idx", int'(GntIdx), i % 16);
         chk("rot_valid", int'(Valid), 1);
         @(negedge Clock);
         chk("rot_gap", int'(Valid), 0);
      end
      Req = '0; Done = 1'b0;

      // Hold limit and timeout pulse
      do_reset();
      @(negedge Clock);
      Req[3] = 1'b1; Req[4] = 1'b1;
      for (int k = 0; k < HOLD; k++) begin
         @(negedge Clock);
         chk("hold_idx3", int'(GntIdx), 3);
         chk("hold_valid", int'(Valid), 1);
      end
      @(negedge Clock);
      chk("hold_rel", int'(Valid), 0);
      chk("hold_to", int'(Timeout), 1);
      @(negedge Clock);
      chk("hold_next4", int'(GntIdx), 4);
      chk("hold_to_off", int'(Timeout), 0);
      repeat (HOLD - 1) @(negedge Clock);
      Done = 1'b1;
      @(negedge Clock);
      chk("limit_done_rel", int'(Valid), 0);
      chk("limit_done_to", int'(Timeout), 0);
      Done = 1'b0; Req = '0;

      // Enable drop keeps pointer, withdraw advances it
      do_reset();
      @(negedge Clock);
      Req[9] = 1'b1;
      @(negedge Clock);
      chk("en_idx9", int'(GntIdx), 9);
      En = 1'b0;
      @(negedge Clock);
      chk("en_rel", int'(Valid), 0);
      En = 1'b1; Req[10] = 1'b1;
      @(negedge Clock);
      chk("en_ptr_kept", int'(GntIdx), 9);
      Req[9] = 1'b0; Req[2] = 1'b1;
      @(negedge Clock);
      chk("wd_rel", int'(Valid), 0);
      chk("wd_to", int'(Timeout), 0);
      @(negedge Clock);
      chk("wd_ptr10", int'(GntIdx), 10);
      Req = '0;

      // Requester 0 against pointer 7
      do_reset();
      @(negedge Clock);
      Req[6] = 1'b1;
      @(negedge Clock);
      Done = 1'b1;
      @(negedge Clock);
      Done = 1'b0; Req = '0; Req[0] = 1'b1; Req[7] = 1'b1;
      @(negedge Clock);
`ifdef ARB_PRIORITY0_EN
      chk("prio0_idx", int'(GntIdx), 0);
`else
      chk("rr_idx7", int'(GntIdx), 7);
`endif
      Req = '0;

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge Clock);
         if ($urandom_range(7) == 0) Req = 16'($urandom);
         Done = ($urandom_range(5) == 0);
         En = ($urandom_range(15) != 0);
      end
      @(negedge Clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
